// File: rtl/bt656_pkg.sv
// bt656_pkg: shared types and constants for the BT.656 receiver.
//   state_t       - receiver FSM states
//   PREAMBLE_*    - timing-reference preamble byte values
//   BLANK_C/Y     - blanking-level chroma/luma used for the filler beat
//   XY_BIT_*      - bit positions inside the XY status byte
//   xy_protect()  - expected P3..P0 protection bits for given F/V/H
package bt656_pkg;

    typedef enum logic [2:0] {
        HUNT,
        Z1,
        Z2,
        XY,
        ACTIVE,
        BLANK
    } state_t;

    localparam logic [7:0] PREAMBLE_FF = 8'hFF;
    localparam logic [7:0] PREAMBLE_00 = 8'h00;
    localparam logic [7:0] BLANK_C     = 8'h80;
    localparam logic [7:0] BLANK_Y     = 8'h10;

    localparam int unsigned XY_BIT_ONE = 7;
    localparam int unsigned XY_BIT_F   = 6;
    localparam int unsigned XY_BIT_V   = 5;
    localparam int unsigned XY_BIT_H   = 4;
    localparam int unsigned XY_BIT_P3  = 3;
    localparam int unsigned XY_BIT_P0  = 0;

    function automatic logic [3:0] xy_protect(input logic f, input logic v, input logic h);
        return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

endpackage

// File: rtl/bt656_xy_decode.sv
// bt656_xy_decode: combinational decode of a BT.656 XY status byte.
//   i_xy  in  8  candidate XY byte
//   o_f   out 1  field bit
//   o_v   out 1  vertical-blanking bit
//   o_h   out 1  0 = SAV, 1 = EAV
//   o_ok  out 1  bit7 set and protection bits consistent (no correction)
module bt656_xy_decode (
    input  logic [7:0] i_xy,
    output logic       o_f,
    output logic       o_v,
    output logic       o_h,
    output logic       o_ok
);
    import bt656_pkg::*;

    logic [3:0] w_prot;

    assign o_f    = i_xy[XY_BIT_F];
    assign o_v    = i_xy[XY_BIT_V];
    assign o_h    = i_xy[XY_BIT_H];
    assign w_prot = xy_protect(o_f, o_v, o_h);
    assign o_ok   = i_xy[XY_BIT_ONE] && (i_xy[XY_BIT_P3:XY_BIT_P0] == w_prot);

endmodule

// File: rtl/bt656_rx.sv
// bt656_rx: BT.656 (625-line, 4:2:2) byte-stream receiver producing one
// Avalon-ST packet of 16-bit {C,Y} beats per active line. No backpressure.
//   pre_clock       in   1  byte clock, rising edge
//   reset           in   1  asynchronous, active-high
//   bt_data         in   8  BT.656 byte, one per edge
//   st_data         out 16  {chroma, luma}
//   st_valid        out  1  beat valid
//   st_sop/st_eop   out  1  first / last beat of a line
//   st_field        out  1  F bit of the SAV that opened the line
//   st_frame_start  out  1  with st_sop on the first active line after V 1->0
//   sync_lock       out  1  valid XY seen within LOCK_TIMEOUT bytes
//   xy_err          out  1  pulse on XY protection failure
//   line_err        out  1  pulse on a short active line
module bt656_rx #(
    parameter int unsigned ACTIVE_WIDTH = 1440,
    parameter int unsigned LOCK_TIMEOUT = 2047
) (
    input  logic        pre_clock,
    input  logic        reset,
    input  logic [7:0]  bt_data,
    output logic [15:0] st_data,
    output logic        st_valid,
    output logic        st_sop,
    output logic        st_eop,
    output logic        st_field,
    output logic        st_frame_start,
    output logic        sync_lock,
    output logic        xy_err,
    output logic        line_err
);
    import bt656_pkg::*;

    localparam int unsigned CNT_W = $clog2(ACTIVE_WIDTH);
    localparam int unsigned WD_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(ACTIVE_WIDTH - 1);
    localparam logic [CNT_W-1:0] FIRST_Y   = CNT_W'(1);
    localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(LOCK_TIMEOUT);

    state_t r_state, w_state_next;

    logic [7:0]       r_bt_q;
    logic [CNT_W-1:0] r_byte_cnt, w_cnt_next;
    logic [7:0]       r_chroma, w_chroma_next;
    logic             r_field, w_field_next;
    logic             r_prev_v, w_prev_v_next;
    logic             r_frame_pending, w_pending_next;
    logic [WD_W-1:0]  r_wdog, w_wdog_next;

    logic [15:0] r_st_data, w_st_data_next;
    logic        r_st_valid, w_st_valid_next;
    logic        r_st_sop, w_st_sop_next;
    logic        r_st_eop, w_st_eop_next;
    logic        r_st_field, w_st_field_next;
    logic        r_st_fs, w_st_fs_next;
    logic        r_sync_lock, w_sync_lock_next;
    logic        r_xy_err, w_xy_err_next;
    logic        r_line_err, w_line_err_next;

    logic w_f, w_v, w_h, w_ok;
    logic w_is_ff, w_is_00, w_xy_valid;

    bt656_xy_decode u_xy_decode (
        .i_xy (r_bt_q),
        .o_f  (w_f),
        .o_v  (w_v),
        .o_h  (w_h),
        .o_ok (w_ok)
    );

    assign w_is_ff    = (r_bt_q == PREAMBLE_FF);
    assign w_is_00    = (r_bt_q == PREAMBLE_00);
    assign w_xy_valid = (r_state == XY) && w_ok;

    // Input stage
    always_ff @(posedge pre_clock or posedge reset) begin
        if (reset) begin
            r_bt_q <= '0;
        end else begin
            r_bt_q <= bt_data;
        end
    end

    // State register
    always_ff @(posedge pre_clock or posedge reset) begin
        if (reset) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; an FF restarts the preamble from any state except XY,
    // where the byte is always treated as the status word.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            HUNT, BLANK: begin
                if (w_is_ff) w_state_next = Z1;
            end
            Z1: begin
                if (w_is_00)      w_state_next = Z2;
                else if (w_is_ff) w_state_next = Z1;
                else              w_state_next = HUNT;
            end
            Z2: begin
                if (w_is_00)      w_state_next = XY;
                else if (w_is_ff) w_state_next = Z1;
                else              w_state_next = HUNT;
            end
            XY: begin
                if (!w_ok)          w_state_next = HUNT;
                else if (w_h || w_v) w_state_next = BLANK;
                else                w_state_next = ACTIVE;
            end
            ACTIVE: begin
                if (w_is_ff)                    w_state_next = Z1;
                else if (r_byte_cnt == LAST_CNT) w_state_next = BLANK;
            end
            default: w_state_next = HUNT;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        w_cnt_next      = r_byte_cnt;
        w_chroma_next   = r_chroma;
        w_field_next    = r_field;
        w_prev_v_next   = r_prev_v;
        w_pending_next  = r_frame_pending;
        w_st_data_next  = '0;
        w_st_valid_next = 1'b0;
        w_st_sop_next   = 1'b0;
        w_st_eop_next   = 1'b0;
        w_st_field_next = 1'b0;
        w_st_fs_next    = 1'b0;
        w_xy_err_next   = 1'b0;
        w_line_err_next = 1'b0;

        if (r_state == XY) begin
            if (w_ok) begin
                w_field_next = w_f;
                if (!w_h) begin
                    if (w_v) begin
                        w_prev_v_next = 1'b1;
                    end else begin
                        w_cnt_next     = '0;
                        w_pending_next = r_prev_v;
                        w_prev_v_next  = 1'b0;
                    end
                end
            end else begin
                w_xy_err_next = 1'b1;
            end
        end

        if (r_state == ACTIVE) begin
            if (w_is_ff) begin
                // Line truncated by a new preamble: close the packet with a
                // blanking-level filler beat; a lone chroma byte is dropped.
                if (r_byte_cnt != '0) begin
                    w_line_err_next = 1'b1;
                    w_st_valid_next = 1'b1;
                    w_st_data_next  = {BLANK_C, BLANK_Y};
                    w_st_eop_next   = 1'b1;
                    w_st_sop_next   = (r_byte_cnt <= FIRST_Y);
                    w_st_fs_next    = (r_byte_cnt <= FIRST_Y) && r_frame_pending;
                    w_st_field_next = r_field;
                end
                w_cnt_next = '0;
            end else begin
                if (!r_byte_cnt[0]) begin
                    w_chroma_next = r_bt_q;
                end else begin
                    w_st_valid_next = 1'b1;
                    w_st_data_next  = {r_chroma, r_bt_q};
                    w_st_sop_next   = (r_byte_cnt == FIRST_Y);
                    w_st_fs_next    = (r_byte_cnt == FIRST_Y) && r_frame_pending;
                    w_st_eop_next   = (r_byte_cnt == LAST_CNT);
                    w_st_field_next = r_field;
                end
                w_cnt_next = (r_byte_cnt == LAST_CNT) ? '0 : r_byte_cnt + 1'b1;
            end
        end

        if (w_xy_valid)            w_wdog_next = '0;
        else if (r_wdog == WD_MAX) w_wdog_next = r_wdog;
        else                       w_wdog_next = r_wdog + 1'b1;

        w_sync_lock_next = w_xy_valid || (r_sync_lock && (w_wdog_next != WD_MAX));
    end

    always_ff @(posedge pre_clock or posedge reset) begin
        if (reset) begin
            r_byte_cnt      <= '0;
            r_chroma        <= '0;
            r_field         <= 1'b0;
            r_prev_v        <= 1'b0;
            r_frame_pending <= 1'b0;
            r_wdog          <= '0;
            r_st_data       <= '0;
            r_st_valid      <= 1'b0;
            r_st_sop        <= 1'b0;
            r_st_eop        <= 1'b0;
            r_st_field      <= 1'b0;
            r_st_fs         <= 1'b0;
            r_sync_lock     <= 1'b0;
            r_xy_err        <= 1'b0;
            r_line_err      <= 1'b0;
        end else begin
            r_byte_cnt      <= w_cnt_next;
            r_chroma        <= w_chroma_next;
            r_field         <= w_field_next;
            r_prev_v        <= w_prev_v_next;
            r_frame_pending <= w_pending_next;
            r_wdog          <= w_wdog_next;
            r_st_data       <= w_st_data_next;
            r_st_valid      <= w_st_valid_next;
            r_st_sop        <= w_st_sop_next;
            r_st_eop        <= w_st_eop_next;
            r_st_field      <= w_st_field_next;
            r_st_fs         <= w_st_fs_next;
            r_sync_lock     <= w_sync_lock_next;
            r_xy_err        <= w_xy_err_next;
            r_line_err      <= w_line_err_next;
        end
    end

    assign st_data        = r_st_data;
    assign st_valid       = r_st_valid;
    assign st_sop         = r_st_sop;
    assign st_eop         = r_st_eop;
    assign st_field       = r_st_field;
    assign st_frame_start = r_st_fs;
    assign sync_lock      = r_sync_lock;
    assign xy_err         = r_xy_err;
    assign line_err       = r_line_err;

endmodule

// File: tb/tb_bt656_rx.sv
// tb_bt656_rx: self-checking bench for bt656_rx. Lines are shortened to keep
// a full 625-line frame within a small cycle budget.
module tb_bt656_rx;

    localparam int AW = 32;
    localparam int LT = 2047;

    logic        pre_clock = 1'b0;
    logic        reset;
    logic [7:0]  bt_data;
    logic [15:0] st_data;
    logic        st_valid, st_sop, st_eop, st_field, st_frame_start;
    logic        sync_lock, xy_err, line_err;

    bt656_rx #(.ACTIVE_WIDTH(AW), .LOCK_TIMEOUT(LT)) dut (
        .pre_clock      (pre_clock),
        .reset          (reset),
        .bt_data        (bt_data),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_sop         (st_sop),
        .st_eop         (st_eop),
        .st_field       (st_field),
        .st_frame_start (st_frame_start),
        .sync_lock      (sync_lock),
        .xy_err         (xy_err),
        .line_err       (line_err)
    );

    always #5 pre_clock = ~pre_clock;

    typedef struct packed {
        logic [15:0] data;
        logic        sop;
        logic        eop;
        logic        field;
        logic        fs;
    } beat_t;

    typedef struct {
        logic [7:0] xy;
        int         exp_err;
        int         exp_beats;
        logic       exp_lock;
        logic       exp_field;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t exp_q[$];
    bit    q_mode = 1'b0;
    bit    m_prev_v = 1'b0;
    int    m_line_err = 0, m_xy_err = 0;
    int    seen_line_err = 0, seen_xy_err = 0, seen_beats = 0, seen_sop = 0, seen_fs = 0;
    logic  last_field = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mk_xy(input bit f, input bit v, input bit h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    function automatic logic [7:0] corrupt(input logic [7:0] xy);
        int k;
        k = $urandom_range(0, 4);
        if (k == 4) return xy & 8'h7F;
        return xy ^ (8'h01 << k);
    endfunction

    // Output monitor: sampled on the falling edge
    always @(negedge pre_clock) begin
        beat_t b;
        if (line_err) seen_line_err++;
        if (xy_err)   seen_xy_err++;
        if (st_valid) begin
            seen_beats++;
            if (st_sop)         seen_sop++;
            if (st_frame_start) seen_fs++;
            last_field = st_field;
            if (q_mode) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL beat_unexpected: got beat %h sop=%0d eop=%0d, expected no beat",
                             st_data, st_sop, st_eop);
                end else begin
                    b = exp_q.pop_front();
                    check("beat", {12'h0, st_data, st_sop, st_eop, st_field, st_frame_start}, {12'h0, b});
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        bt_data = b;
        @(posedge pre_clock);
        #1;
    endtask

    task automatic send_pre(input logic [7:0] xy);
        send(8'hFF); send(8'h00); send(8'h00); send(xy);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        m_prev_v = 1'b0;
        repeat (2) @(posedge pre_clock);
        #1;
        reset = 1'b0;
        m_line_err = seen_line_err;
        m_xy_err   = seen_xy_err;
    endtask

    task automatic checkpoint(input string tag);
        repeat (4) send(8'h10);
        check({tag, "_line_err"}, seen_line_err, m_line_err);
        check({tag, "_xy_err"}, seen_xy_err, m_xy_err);
        check({tag, "_beats_left"}, exp_q.size(), 0);
    endtask

    // One line: SAV, nbytes of payload, EAV, horizontal blanking.
    // Expected beats are derived from the line description.
    task automatic send_line(input bit f, input bit v, input int nbytes, input bit patterned,
                             input logic [7:0] luma, input bit extra_ff,
                             input bit bad_sav, input bit bad_eav);
        logic [7:0] sav, eav, d, cb;
        bit active, pend;
        beat_t b;
        sav = mk_xy(f, v, 1'b0);
        if (bad_sav) sav = corrupt(sav);
        active = !bad_sav && !v;
        pend = 1'b0;
        if (bad_sav) m_xy_err++;
        else if (v) m_prev_v = 1'b1;
        else begin
            pend = m_prev_v;
            m_prev_v = 1'b0;
        end
        if (extra_ff) send(8'hFF);
        send_pre(sav);
        cb = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            if (!active)        d = (i % 2 == 0) ? 8'h80 : 8'h10;
            else if (patterned) d = (i % 2 == 0) ? 8'h99 : luma;
            else                d = 8'($urandom_range(1, 254));
            if (active) begin
                if (i % 2 == 0) cb = d;
                else begin
                    b.data = {cb, d}; b.sop = (i == 1); b.eop = (i == AW - 1);
                    b.field = f; b.fs = (i == 1) && pend;
                    exp_q.push_back(b);
                end
            end
            send(d);
        end
        if (active && nbytes > 0 && nbytes < AW) begin
            b.data = 16'h8010; b.sop = (nbytes < 2); b.eop = 1'b1;
            b.field = f; b.fs = (nbytes < 2) && pend;
            exp_q.push_back(b);
            m_line_err++;
        end
        eav = mk_xy(f, v, 1'b1);
        if (bad_eav) begin
            eav = corrupt(eav);
            m_xy_err++;
        end
        send_pre(eav);
        repeat (4) begin send(8'h80); send(8'h10); end
    endtask

    function automatic logic [23:0] all_outs();
        return {st_data, st_valid, st_sop, st_eop, st_field, st_frame_start, sync_lock, xy_err, line_err};
    endfunction

    vec_t tbl[13];

    initial begin
        int s_sop, s_fs, s_beats, snap;
        bit f, v;
        logic [7:0] luma;
        int nb, r;

        bt_data = 8'h00;
        reset   = 1'b1;
        repeat (3) @(posedge pre_clock);
        #1;
        check("reset_outputs", all_outs(), 24'h0);
        reset = 1'b0;
        send(8'h10);
        check("idle_outputs", all_outs(), 24'h0);

        // XY decode table: each vector follows a fresh reset
        tbl[0]  = '{8'h80, 0, AW/2, 1'b1, 1'b0};
        tbl[1]  = '{8'h81, 1, 0,    1'b0, 1'b0};
        tbl[2]  = '{8'h9D, 0, 0,    1'b1, 1'b0};
        tbl[3]  = '{8'hAB, 0, 0,    1'b1, 1'b0};
        tbl[4]  = '{8'hB6, 0, 0,    1'b1, 1'b0};
        tbl[5]  = '{8'hC7, 0, AW/2, 1'b1, 1'b1};
        tbl[6]  = '{8'hDA, 0, 0,    1'b1, 1'b0};
        tbl[7]  = '{8'hEC, 0, 0,    1'b1, 1'b0};
        tbl[8]  = '{8'hF1, 0, 0,    1'b1, 1'b0};
        tbl[9]  = '{8'h00, 1, 0,    1'b0, 1'b0};
        tbl[10] = '{8'h7F, 1, 0,    1'b0, 1'b0};
        tbl[11] = '{8'hC6, 1, 0,    1'b0, 1'b0};
        tbl[12] = '{8'h84, 1, 0,    1'b0, 1'b0};
        q_mode = 1'b0;
        for (int t = 0; t < 13; t++) begin
            do_reset();
            seen_beats = 0; seen_xy_err = 0;
            send_pre(tbl[t].xy);
            for (int i = 0; i < AW; i++) send((i % 2 == 0) ? 8'h99 : 8'(8'h20 + i));
            send(8'h10); send(8'h10);
            check($sformatf("xy%02h_beats", tbl[t].xy), seen_beats, tbl[t].exp_beats);
            check($sformatf("xy%02h_err", tbl[t].xy), seen_xy_err, tbl[t].exp_err);
            check($sformatf("xy%02h_lock", tbl[t].xy), sync_lock, tbl[t].exp_lock);
            if (tbl[t].exp_beats > 0)
                check($sformatf("xy%02h_field", tbl[t].xy), last_field, tbl[t].exp_field);
        end

        // Two-edge latency from Y byte to beat
        do_reset();
        seen_beats = 0;
        send_pre(8'h80);
        send(8'h99);
        send(8'h42);
        check("latency_not_yet", st_valid, 1'b0);
        send(8'h98);
        check("latency_beat", {st_valid, st_sop, st_frame_start, st_eop, st_data}, {4'b1100, 16'h9942});
        for (int i = 3; i < AW; i++) send((i % 2 == 0) ? 8'h98 : 8'h43);
        send_pre(8'h9D);
        check("latency_line_beats", seen_beats, AW / 2);

        // Full 625-line frame
        do_reset();
        q_mode = 1'b1;
        s_sop = seen_sop; s_fs = seen_fs; s_beats = seen_beats;
        for (int line = 1; line <= 625; line++) begin
            f = (line >= 313);
            v = (line <= 22) || (line >= 311 && line <= 335) || (line >= 624);
            luma = 8'(line);
            if (luma == 8'hFF) luma = 8'hFE;   // 0xFF would terminate the line
            send_line(f, v, AW, 1'b1, luma, 1'b0, 1'b0, 1'b0);
        end
        checkpoint("frame");
        check("frame_packets", seen_sop - s_sop, 576);
        check("frame_starts", seen_fs - s_fs, 2);
        check("frame_beats", seen_beats - s_beats, 576 * AW / 2);

        // Short lines, empty line, single-byte line, odd length
        send_line(1'b0, 1'b1, AW, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0);
        send_line(1'b0, 1'b0, 20, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0);
        send_line(1'b0, 1'b0, 0,  1'b0, 8'h0, 1'b0, 1'b0, 1'b0);
        send_line(1'b1, 1'b0, 1,  1'b0, 8'h0, 1'b0, 1'b0, 1'b0);
        send_line(1'b1, 1'b0, 7,  1'b0, 8'h0, 1'b0, 1'b0, 1'b0);
        checkpoint("short");
        // Doubled FF in preamble
        send_line(1'b0, 1'b0, AW, 1'b0, 8'h0, 1'b1, 1'b0, 1'b0);
        checkpoint("ff_ff");

        // Randomized lines
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            nb = (r == 0) ? 0 : (r == 1) ? 1 : (r <= 3) ? $urandom_range(2, AW - 1) : AW;
            send_line(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), nb, 1'b0, 8'h0,
                      ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 9) == 0));
        end
        checkpoint("random");

        // Watchdog
        s_beats = seen_beats;
        send_pre(8'h9D);
        for (int i = 1; i <= 3000; i++) begin
            send(8'h55);
            if (i == 2047) check("wdog_still_locked", sync_lock, 1'b1);
            if (i == 2048) check("wdog_lock_dropped", sync_lock, 1'b0);
        end
        check("wdog_lock_saturated", sync_lock, 1'b0);
        check("wdog_no_beats", seen_beats - s_beats, 0);

        // Reset mid-line
        do_reset();
        q_mode = 1'b0;
        seen_beats = 0;
        send_line(1'b0, 1'b1, AW, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0);
        send_pre(8'h80);
        for (int i = 0; i < 16; i++) send((i % 2 == 0) ? 8'h99 : 8'h31);
        reset = 1'b1;
        #1;
        check("midreset_outputs_async", all_outs(), 24'h0);
        snap = seen_beats;
        check("midreset_beats_before", snap, 7);
        repeat (5) send(8'h41);
        check("midreset_outputs_held", all_outs(), 24'h0);
        reset = 1'b0;
        exp_q.delete();
        m_prev_v = 1'b0;
        m_line_err = seen_line_err;
        m_xy_err   = seen_xy_err;
        repeat (AW / 2) send(8'h41);
        send_pre(8'h9D);
        repeat (4) send(8'h10);
        check("midreset_no_beats_after", seen_beats, snap);
        q_mode = 1'b1;
        s_fs = seen_fs;
        send_line(1'b0, 1'b0, AW, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        checkpoint("after_reset");
        check("after_reset_beats", seen_beats - snap, AW / 2);
        check("after_reset_no_fs", seen_fs - s_fs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
